// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory miss controller: FSM state codes and
// the mem_write_o direction values.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WB     = 2'b01,
    REFILL = 2'b10,
    DONE   = 2'b11
  } state_e;

  localparam logic MEM_WR_WRITEBACK = 1'b1;
  localparam logic MEM_WR_REFILL    = 1'b0;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Watchdog for backing-memory transfers: counts waiting cycles and flags expiry
// on the cycle whose increment would bring the count to TIMEOUT-1.
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] CNT_MAX   = W'(TIMEOUT - 1);
  localparam logic [W-1:0] EXPIRE_AT = W'(TIMEOUT - 2);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over enable; the count parks at its maximum instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/dmem_miss_ctrl.sv
// MEM-stage data-cache miss sequencer: stalls the pipeline and runs writeback/refill.
// Optional performance counters are enabled with `define DMEM_PERF_CNT_EN.
module dmem_miss_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
`ifdef DMEM_PERF_CNT_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             hit_i,
  input  logic             dirty_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic             refill_o,
  output logic             set_dirty_o,
  output logic             stall_o,
  output logic             err_o,
`ifdef DMEM_PERF_CNT_EN
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o,
`endif
  output logic [1:0]       state_o
);

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   access;
  logic   wd_en, wd_clr, wd_expire;

  assign access = MemRead_i | MemWrite_i;
  assign wd_en  = ((state_q == WB) || (state_q == REFILL)) && !mem_ack_i;
  assign wd_clr = mem_ack_i || (state_d != state_q);

  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    refill_o    = 1'b0;
    set_dirty_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (hit_i) begin
            set_dirty_o = MemWrite_i;
          end else begin
            stall_o = 1'b1;
            state_d = dirty_i ? WB : REFILL;
          end
        end
      end
      WB: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_write_o = MEM_WR_WRITEBACK;
        if (mem_ack_i) begin
          state_d = REFILL;
        end else if (wd_expire) begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_write_o = MEM_WR_REFILL;
        if (mem_ack_i) begin
          refill_o = 1'b1;
          state_d  = DONE;
        end else if (wd_expire) begin
          state_d = IDLE;
        end
      end
      // One bubble so the cache array re-reads the freshly written line.
      DONE: begin
        stall_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = err_q | wd_expire;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err_o   = err_q;
  assign state_o = state_q;

`ifdef DMEM_PERF_CNT_EN
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic             miss_start;

  assign miss_start = (state_q == IDLE) && (state_d != IDLE);

  // Saturating counters: they hold at all-ones rather than wrapping.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (miss_start && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
    if (miss_start && (state_d == WB) && (wb_cnt_q != '1)) begin
      wb_cnt_d = wb_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule
